// File: rtl/stepper_phase_decoder.sv
// Decodes a 4-phase stepper coil bus into step strobes, direction and a signed position count.
// Define STALL_DETECT_EN to build the stall detector; without it, stalled is tied low.
module stepper_phase_decoder #(
  parameter int unsigned POS_WIDTH    = 16,
  parameter int unsigned STALL_CYCLES = 32'd2_000_000
) (
  input  logic                        CLK100MHZ,
  input  logic                        reset,
  input  logic [3:0]                  coil,
  input  logic                        zero,
  input  logic                        clear_err,
  output logic                        step_pulse,
  output logic                        dir,
  output logic signed [POS_WIDTH-1:0] position,
  output logic [1:0]                  phase,
  output logic                        valid,
  output logic                        skip_err,
  output logic                        illegal_err,
  output logic                        stalled
);

  typedef enum logic {
    WAIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [3:0]                  sync1_q, sync2_q;
  logic                        stepPulse_q, stepPulse_d;
  logic                        dir_q, dir_d;
  logic signed [POS_WIDTH-1:0] position_q, position_d;
  logic [1:0]                  phase_q, phase_d;
  logic                        skipErr_q, skipErr_d;
  logic                        illegalErr_q, illegalErr_d;

  logic       legal;
  logic [1:0] newIdx;
  logic [1:0] delta;

  always_comb begin
    legal  = 1'b1;
    newIdx = 2'd0;
    case (sync2_q)
      4'b1001: newIdx = 2'd0;
      4'b1010: newIdx = 2'd1;
      4'b0110: newIdx = 2'd2;
      4'b0101: newIdx = 2'd3;
      default: legal  = 1'b0;
    endcase
  end

  assign delta = newIdx - phase_q;

  // Illegal patterns only count as errors once tracking: the cleared synchronizer
  // and an idle drive both read 0000, which must not raise a flag before the first phase.
  always_comb begin
    state_d      = state_q;
    stepPulse_d  = 1'b0;
    dir_d        = dir_q;
    position_d   = position_q;
    phase_d      = phase_q;
    skipErr_d    = skipErr_q;
    illegalErr_d = illegalErr_q;

    if (clear_err) begin
      skipErr_d    = 1'b0;
      illegalErr_d = 1'b0;
    end

    case (state_q)
      WAIT: begin
        if (legal) begin
          state_d = TRACK;
          phase_d = newIdx;
        end
      end
      TRACK: begin
        if (!legal) begin
          illegalErr_d = 1'b1;
        end else begin
          case (delta)
            2'd3: begin
              stepPulse_d = 1'b1;
              dir_d       = 1'b1;
              phase_d     = newIdx;
              position_d  = position_q + POS_WIDTH'(1);
            end
            2'd1: begin
              stepPulse_d = 1'b1;
              dir_d       = 1'b0;
              phase_d     = newIdx;
              position_d  = position_q - POS_WIDTH'(1);
            end
            2'd2: begin
              skipErr_d = 1'b1;
              phase_d   = newIdx;
            end
            default: ;
          endcase
        end
      end
      default: state_d = WAIT;
    endcase

    if (zero) begin
      position_d = '0;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      state_q      <= WAIT;
      stepPulse_q  <= 1'b0;
      dir_q        <= 1'b0;
      position_q   <= '0;
      phase_q      <= '0;
      skipErr_q    <= 1'b0;
      illegalErr_q <= 1'b0;
    end else begin
      sync1_q      <= coil;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      stepPulse_q  <= stepPulse_d;
      dir_q        <= dir_d;
      position_q   <= position_d;
      phase_q      <= phase_d;
      skipErr_q    <= skipErr_d;
      illegalErr_q <= illegalErr_d;
    end
  end

  assign step_pulse  = stepPulse_q;
  assign dir         = dir_q;
  assign position    = position_q;
  assign phase       = phase_q;
  assign valid       = (state_q == TRACK);
  assign skip_err    = skipErr_q;
  assign illegal_err = illegalErr_q;

`ifdef STALL_DETECT_EN
  logic [31:0] stallCnt_q, stallCnt_d;
  logic        stalled_q, stalled_d;

  // Counter saturates at STALL_CYCLES so stalled holds until the next step restarts it.
  always_comb begin
    stallCnt_d = stallCnt_q;
    stalled_d  = stalled_q;
    if (state_q != TRACK) begin
      stallCnt_d = '0;
      stalled_d  = 1'b0;
    end else if (stepPulse_d) begin
      stallCnt_d = '0;
      stalled_d  = 1'b0;
    end else begin
      if (stallCnt_q != STALL_CYCLES) begin
        stallCnt_d = stallCnt_q + 32'd1;
      end
      stalled_d = (stallCnt_d == STALL_CYCLES);
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      stallCnt_q <= '0;
      stalled_q  <= 1'b0;
    end else begin
      stallCnt_q <= stallCnt_d;
      stalled_q  <= stalled_d;
    end
  end

  assign stalled = stalled_q;
`else
  assign stalled = 1'b0;
`endif

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Directed self-checking bench for stepper_phase_decoder; stall expectations follow STALL_DETECT_EN.
module tb_stepper_phase_decoder;

  logic        clk;
  logic        reset;
  logic [3:0]  coil;
  logic        zero;
  logic        clearErr;
  logic        stepPulse;
  logic        dir;
  logic signed [15:0] position;
  logic [1:0]  phase;
  logic        valid;
  logic        skipErr;
  logic        illegalErr;
  logic        stalled;

  int errorCount = 0;
  int checkCount = 0;
  int pulseCount = 0;
  logic [3:0] patTable [4] = '{4'b1001, 4'b1010, 4'b0110, 4'b0101};
  logic       expStalled;
  logic [1:0] idx;
  int         pulsesBefore;

  stepper_phase_decoder #(
    .POS_WIDTH   (16),
    .STALL_CYCLES(100)
  ) dut (
    .CLK100MHZ  (clk),
    .reset      (reset),
    .coil       (coil),
    .zero       (zero),
    .clear_err  (clearErr),
    .step_pulse (stepPulse),
    .dir        (dir),
    .position   (position),
    .phase      (phase),
    .valid      (valid),
    .skip_err   (skipErr),
    .illegal_err(illegalErr),
    .stalled    (stalled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (stepPulse) pulseCount++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] coilVal, input int holdCycles);
    coil = coilVal;
    tick(holdCycles);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  initial begin
`ifdef STALL_DETECT_EN
    expStalled = 1'b1;
`else
    expStalled = 1'b0;
`endif
    reset    = 1'b1;
    coil     = 4'b0000;
    zero     = 1'b0;
    clearErr = 1'b0;
    tick(3);
    checkOutput("rst_step_pulse", {31'b0, stepPulse}, 32'd0);
    checkOutput("rst_dir", {31'b0, dir}, 32'd0);
    checkOutput("rst_position", {16'b0, position}, 32'd0);
    checkOutput("rst_phase", {30'b0, phase}, 32'd0);
    checkOutput("rst_valid", {31'b0, valid}, 32'd0);
    checkOutput("rst_skip_err", {31'b0, skipErr}, 32'd0);
    checkOutput("rst_illegal_err", {31'b0, illegalErr}, 32'd0);
    checkOutput("rst_stalled", {31'b0, stalled}, 32'd0);
    reset = 1'b0;
    tick(2);
    checkOutput("idle_no_illegal", {31'b0, illegalErr}, 32'd0);

    // First legal pattern: visible after the third edge, no step counted
    applyStimulus(4'b1001, 2);
    checkOutput("acquire_latency_valid", {31'b0, valid}, 32'd0);
    tick(1);
    checkOutput("acquire_valid", {31'b0, valid}, 32'd1);
    checkOutput("acquire_phase", {30'b0, phase}, 32'd0);
    checkOutput("acquire_position", {16'b0, position}, 32'd0);
    checkOutput("acquire_no_pulse", pulseCount, 32'd0);

    // CW sequence with single-cycle strobe latency check on the first step
    applyStimulus(4'b0101, 2);
    checkOutput("cw_latency_pulse_low", {31'b0, stepPulse}, 32'd0);
    tick(1);
    checkOutput("cw_pulse_high", {31'b0, stepPulse}, 32'd1);
    tick(1);
    checkOutput("cw_pulse_one_cycle", {31'b0, stepPulse}, 32'd0);
    tick(6);
    applyStimulus(4'b0110, 10);
    applyStimulus(4'b1010, 10);
    applyStimulus(4'b1001, 10);
    checkOutput("cw_pulse_count", pulseCount, 32'd4);
    checkOutput("cw_dir", {31'b0, dir}, 32'd1);
    checkOutput("cw_position", {16'b0, position}, 32'd4);
    checkOutput("cw_phase", {30'b0, phase}, 32'd0);

    // CCW back to zero
    applyStimulus(4'b1010, 10);
    applyStimulus(4'b0110, 10);
    applyStimulus(4'b0101, 10);
    applyStimulus(4'b1001, 10);
    checkOutput("ccw_pulse_count", pulseCount, 32'd8);
    checkOutput("ccw_dir", {31'b0, dir}, 32'd0);
    checkOutput("ccw_position", {16'b0, position}, 32'd0);

    // Two-phase jump
    applyStimulus(4'b0110, 10);
    checkOutput("skip_flag", {31'b0, skipErr}, 32'd1);
    checkOutput("skip_phase", {30'b0, phase}, 32'd2);
    checkOutput("skip_position", {16'b0, position}, 32'd0);
    checkOutput("skip_no_pulse", pulseCount, 32'd8);
    clearErr = 1'b1;
    tick(1);
    clearErr = 1'b0;
    checkOutput("skip_cleared", {31'b0, skipErr}, 32'd0);

    // Re-acquire from reset with a legal pattern already present
    reset = 1'b1;
    coil  = 4'b1001;
    tick(2);
    reset = 1'b0;
    tick(3);
    checkOutput("reacq_valid", {31'b0, valid}, 32'd1);
    checkOutput("reacq_position", {16'b0, position}, 32'd0);
    checkOutput("reacq_no_pulse", pulseCount, 32'd8);

    // Illegal pattern holds phase; next legal compared to held phase
    applyStimulus(4'b1111, 5);
    checkOutput("illegal_flag", {31'b0, illegalErr}, 32'd1);
    checkOutput("illegal_phase_held", {30'b0, phase}, 32'd0);
    checkOutput("illegal_position_held", {16'b0, position}, 32'd0);
    applyStimulus(4'b0101, 5);
    checkOutput("after_illegal_position", {16'b0, position}, 32'd1);
    checkOutput("after_illegal_dir", {31'b0, dir}, 32'd1);
    checkOutput("after_illegal_phase", {30'b0, phase}, 32'd3);

    // Clear coinciding with a fresh error: set wins
    applyStimulus(4'b1111, 5);
    clearErr = 1'b1;
    tick(1);
    clearErr = 1'b0;
    checkOutput("clear_vs_set", {31'b0, illegalErr}, 32'd1);
    applyStimulus(4'b0101, 4);
    clearErr = 1'b1;
    tick(1);
    clearErr = 1'b0;
    checkOutput("illegal_cleared", {31'b0, illegalErr}, 32'd0);
    checkOutput("sustained_no_step", {16'b0, position}, 32'd1);

    // Wrap check: reset, then one CW step per cycle up to 0x7FFF
    reset = 1'b1;
    coil  = 4'b1001;
    tick(2);
    reset = 1'b0;
    tick(3);
    idx = 2'd0;
    for (int i = 0; i < 32767; i++) begin
      idx  = idx - 2'd1;
      coil = patTable[idx];
      tick(1);
    end
    tick(2);
    checkOutput("fast_position_max", {16'b0, position}, 32'h7FFF);
    checkOutput("fast_phase", {30'b0, phase}, 32'd1);
    applyStimulus(4'b1001, 3);
    checkOutput("wrap_position", {16'b0, position}, 32'h8000);
    checkOutput("wrap_pulse", {31'b0, stepPulse}, 32'd1);
    tick(2);

    // zero on the edge that registers the step
    coil = 4'b0101;
    tick(2);
    zero = 1'b1;
    tick(1);
    zero = 1'b0;
    checkOutput("zero_step_pulse", {31'b0, stepPulse}, 32'd1);
    checkOutput("zero_position", {16'b0, position}, 32'd0);
    checkOutput("zero_phase", {30'b0, phase}, 32'd3);
    checkOutput("zero_dir", {31'b0, dir}, 32'd1);

    // Stall detector: 100-cycle threshold counted from that step
    tick(50);
    checkOutput("stall_early", {31'b0, stalled}, 32'd0);
    tick(60);
    checkOutput("stall_asserted", {31'b0, stalled}, {31'b0, expStalled});
    applyStimulus(4'b0110, 3);
    checkOutput("stall_step_pulse", {31'b0, stepPulse}, 32'd1);
    checkOutput("stall_cleared", {31'b0, stalled}, 32'd0);
    checkOutput("stall_position", {16'b0, position}, 32'd1);

    // Reset beats zero/clear/coil change in the same cycle
    reset    = 1'b1;
    zero     = 1'b1;
    clearErr = 1'b1;
    coil     = 4'b1010;
    tick(1);
    zero     = 1'b0;
    clearErr = 1'b0;
    checkOutput("midrst_valid", {31'b0, valid}, 32'd0);
    checkOutput("midrst_position", {16'b0, position}, 32'd0);
    checkOutput("midrst_phase", {30'b0, phase}, 32'd0);
    checkOutput("midrst_dir", {31'b0, dir}, 32'd0);
    tick(1);
    reset = 1'b0;
    pulsesBefore = pulseCount;
    tick(3);
    checkOutput("post_rst_valid", {31'b0, valid}, 32'd1);
    checkOutput("post_rst_phase", {30'b0, phase}, 32'd1);
    checkOutput("post_rst_position", {16'b0, position}, 32'd0);
    checkOutput("post_rst_no_pulse", pulseCount - pulsesBefore, 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/stepper_phase_decoder.md
STEPPER_PHASE_DECODER -- requirements
Module: stepper_phase_decoder

Interface
REQ-001 SHALL have parameter POS_WIDTH, default 16: width of the signed position counter.
REQ-002 SHALL have parameter STALL_CYCLES, default 32'd2_000_000: cycles without a step before stalled asserts (20 ms at 100 MHz).
REQ-003 SHALL have port CLK100MHZ  input  1  system clock; single clock domain.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port coil  input  4  asynchronous coil lines {jb1,jb2,jb3,jb4} from a 4-phase stepper drive.
REQ-006 SHALL have port zero  input  1  synchronous position clear.
REQ-007 SHALL have port clear_err  input  1  synchronous clear of the sticky error flags.
REQ-008 SHALL have port step_pulse  output  1  one-cycle strobe per decoded step.
REQ-009 SHALL have port dir  output  1  direction of the last step (1 = CW, 0 = CCW).
REQ-010 SHALL have port position  output  POS_WIDTH  signed step count (CW +1, CCW -1).
REQ-011 SHALL have port phase  output  2  last legal phase index.
REQ-012 SHALL have port valid  output  1  a legal pattern has been seen since reset.
REQ-013 SHALL have port skip_err  output  1  sticky flag for a two-phase jump.
REQ-014 SHALL have port illegal_err  output  1  sticky flag for a non-phase pattern.
REQ-015 SHALL have port stalled  output  1  no step for STALL_CYCLES while valid.

Function
REQ-016 SHALL pass coil through a 2-flop synchronizer before any decoding.
REQ-017 SHALL decode the synchronized pattern as 1001 = index 0, 1010 = 1, 0110 = 2, 0101 = 3; every other value is illegal.
REQ-018 SHALL register all outputs in the cycle after the second synchronizer stage, so a coil change before edge k is visible after edge k+2.
REQ-019 SHALL run a two-state machine: WAIT (valid=0) and TRACK (valid=1); WAIT moves to TRACK on the first legal pattern, loading phase without counting a step.
REQ-020 In TRACK, SHALL compute d = (new - phase) mod 4 on every legal sample: d=0 no action; d=3 CW step; d=1 CCW step; d=2 sets skip_err, loads phase, no step.
REQ-021 On a CW or CCW step, SHALL pulse step_pulse for exactly one cycle, update dir, load phase, and add +1 (CW) or -1 (CCW) to position.
REQ-022 SHALL treat position as two's complement and wrap modulo 2^POS_WIDTH (0x7FFF +1 -> 0x8000 when POS_WIDTH=16).
REQ-023 On an illegal pattern, SHALL set illegal_err, hold phase, dir and position, and leave the state unchanged; the next legal pattern is compared against the held phase.
REQ-024 When zero and a step coincide, SHALL load position = 0 while still pulsing step_pulse and updating dir and phase.
REQ-025 When clear_err and a new error coincide, SHALL leave the flag set (set wins).
REQ-026 A sustained pattern SHALL produce no further step_pulse.

Reset
REQ-027 On reset, SHALL clear both synchronizer stages, go to WAIT, and drive step_pulse=0, dir=0, position=0, phase=0, valid=0, skip_err=0, illegal_err=0, stalled=0, with the stall counter at 0.
REQ-028 Reset asserted mid-tracking SHALL take priority over every other input in the same cycle, and the block SHALL re-enter WAIT with no step counted on the first pattern after release.

Configuration
REQ-029 With STALL_DETECT_EN defined, SHALL count cycles in TRACK, restart the count on each step_pulse, assert stalled when the count reaches STALL_CYCLES, saturate the counter there, and clear stalled on the next step.
REQ-030 Without STALL_DETECT_EN, SHALL omit the stall counter entirely and tie stalled to 0.

Verification
REQ-031 Reset, then apply coil 1001 -> valid=1 and phase=0 after 3 edges, position=0, no step_pulse.
REQ-032 Apply sequence 1001,0101,0110,1010,1001, each held 10 cycles -> 4 step_pulses, dir=1, position=4; the reverse order then returns position to 0 with dir=0.
REQ-033 Apply 1001 then 0110 -> skip_err=1, phase=2, position unchanged; assert clear_err for 1 cycle -> skip_err=0.
REQ-034 Apply 1111 while at phase 0, then 0101 -> illegal_err=1 with phase held at 0; the 0101 counts as a CW step and position goes +1.
REQ-035 Preset position to 0x7FFF with POS_WIDTH=16 and apply a CW step -> position=0x8000; assert zero in the same cycle as the step_pulse -> position=0 and step_pulse still asserted.
REQ-036 With STALL_DETECT_EN and STALL_CYCLES=100, hold one phase for 100 cycles -> stalled=1; the next step -> stalled=0; without the macro, stalled stays 0.
